xilinx_sp_bram_arbiter: RTL
===========================

// Module: xilinx_sp_bram_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing one xilinx_sp_bram between NUM_REQ requesters.
//  Accepts read/write requests over valid/ready, issues at most one BRAM access per cycle,
//  tracks in-flight reads through the BRAM latency (1+DO_REG) and returns each read's data
//  to the issuing requester. Sits between client logic and the BRAM port pins.
// PARAMETERS
//  NUM_REQ     4    number of requesters (1..16)
//  ADDR_WIDTH  10   requester address width (<=15), zero-extended onto BRAM_ADDR
//  DATA_WIDTH  36   read/write data width; equals BRAM READ_WIDTH = WRITE_WIDTH
//  WE_WIDTH    4    byte-enable width per BRAM depth table (1,2,4,8)
//  DO_REG      0    must equal the BRAM DO_REG (0 or 1); sets read latency
// PORTS
//  CLK         in   1                     clock
//  RST_N       in   1                     async active-low reset
//  REQ_VALID   in   NUM_REQ               per-requester request valid
//  REQ_READY   out  NUM_REQ               one-hot grant; transfer when VALID&READY
//  REQ_WR      in   NUM_REQ               1=write, 0=read
//  REQ_BE      in   NUM_REQ*WE_WIDTH      write byte enables (ignored on read)
//  REQ_ADDR    in   NUM_REQ*ADDR_WIDTH    request address
//  REQ_WDATA   in   NUM_REQ*DATA_WIDTH    write data
//  RSP_VALID   out  NUM_REQ               one-hot read-data valid, single cycle, no backpressure
//  RSP_DATA    out  DATA_WIDTH            read data, shared bus, qualified by RSP_VALID
//  BRAM_EN     out  1                     to BRAM EN
//  BRAM_WE     out  8                     to BRAM WE; [WE_WIDTH-1:0]=BE on write, else 0
//  BRAM_ADDR   out  15                    to BRAM ADDR
//  BRAM_DI     out  DATA_WIDTH            to BRAM DI
//  BRAM_REGCE  out  1                     to BRAM REGCE (held 0 when DO_REG=0)
//  BRAM_DO     in   DATA_WIDTH            from BRAM DO
// BEHAVIOUR
//  - Reset (RST_N=0, async): REQ_READY=0, RSP_VALID=0, BRAM_EN=0, BRAM_WE=0, BRAM_ADDR=0,
//    BRAM_DI=0, BRAM_REGCE=0, RR pointer=0, tag pipeline cleared. BRAM RST tied 0 by instantiator.
//  - Arbitration: combinational round-robin over REQ_VALID starting at pointer; REQ_READY is
//    one-hot (or zero if no valid). Pointer <= granted index+1 (mod NUM_REQ) only on a grant.
//    Requester must hold VALID and payload stable until READY; READY may not depend on it dropping.
//  - Issue: accept in cycle t -> registered BRAM_EN=1, WE/ADDR/DI driven in t+1; idle cycles EN=0, WE=0.
//  - Writes: complete at issue; no response. Reads: tag {valid,id} enters pipeline of depth 1+DO_REG.
//  - DO_REG=1: BRAM_REGCE=1 in cycle t+2 exactly when a read tag is at stage 1, else 0.
//  - Response: RSP_VALID[id]=1 in cycle t+2+DO_REG; RSP_DATA = BRAM_DO passthrough that cycle.
//    RSP_DATA unqualified when RSP_VALID=0.
//  - Throughput: one access/cycle; back-to-back reads from any mix of requesters, responses in issue order.
//  - Simultaneous: read and write to same address in consecutive cycles execute in accept order;
//    same-cycle conflict impossible (single grant).
//  - NUM_REQ=1: grant whenever valid; pointer constant 0.
//  - Reset mid-operation: in-flight reads dropped, no RSP_VALID after release; first grant after
//    release goes to lowest valid index.
//  - Address: BRAM_ADDR = {zeros, REQ_ADDR}; no range check; wrap is requester's responsibility.
// STRUCTURE
//  - xilinx_primitive_pkg: localparam MAX_REQ=16, function rd_latency(do_reg)=1+do_reg,
//    typedef rd_tag_t {logic vld; logic [3:0] id;}.
//  - Sub-module xilinx_rr_arbiter (NUM_REQ): req, advance -> one-hot gnt, gnt index; owns pointer.
//  - Top holds issue register and tag shift register; instantiates no BRAM itself.
// TESTING (bench pairs DUT with xilinx_sp_bram model, DO_REG 0 and 1)
//  - Req0 write addr 0x005 data 0x123456789 BE=0xF, then req0 read 0x005 -> RSP_VALID[0] 2 cycles
//    after read accept (3 with DO_REG=1), RSP_DATA=0x123456789.
//  - All 4 requesters valid continuously -> grants 0,1,2,3,0,... one per cycle; each READY every 4th cycle.
//  - Req2 then req1 reads of addr 2/1 holding 0xAA/0xBB back-to-back -> RSP_VALID 0x4 then 0x2
//    on consecutive cycles with 0xAA then 0xBB.
//  - Partial write BE=0x1 data 0xFF to word 0x000000000 -> readback 0x0000000FF.
//  - Assert RST_N low one cycle after a read accept -> no RSP_VALID afterwards, all outputs 0 in reset.
//  - Only req3 valid after pointer=1 -> granted immediately; pointer becomes 0.

Source files
------------

// File: rtl/xilinx_primitive_pkg.sv
// Shared types and constants for the single-port BRAM arbiter.
//   MAX_REQ     : upper bound on requester count (sets tag id width)
//   rd_tag_t    : in-flight read tag {vld, id}
//   rd_latency  : BRAM read latency in cycles for a given DO_REG setting
package xilinx_primitive_pkg;

    localparam int unsigned MAX_REQ     = 16;
    localparam int unsigned TAG_ID_W    = $clog2(MAX_REQ);
    localparam int unsigned BRAM_ADDR_W = 15;
    localparam int unsigned BRAM_WE_W   = 8;

    typedef struct packed {
        logic                vld;
        logic [TAG_ID_W-1:0] id;
    } rd_tag_t;

    function automatic int unsigned rd_latency(input int unsigned do_reg);
        return 32'd1 + do_reg;
    endfunction

endpackage

// File: rtl/xilinx_rr_arbiter.sv
// Round-robin arbiter with an internal rotating priority pointer.
//   clk, rst_n  : clock, async active-low reset
//   req         : per-requester request
//   advance     : a grant was taken this cycle; move pointer past the winner
//   gnt_c       : one-hot grant (combinational), zero when no request
//   gnt_idx_c   : index of the granted requester (combinational)
module xilinx_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] gnt_c,
    output logic [IDX_W-1:0]   gnt_idx_c
);

    logic [IDX_W-1:0] ptr_q;
    logic             found_c;
    int unsigned      cand_c;

    // First requesting index at or after the pointer, wrapping around.
    always_comb begin
        gnt_idx_c = '0;
        found_c   = 1'b0;
        cand_c    = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand_c = (32'(ptr_q) + i) % NUM_REQ;
            if (!found_c && req[IDX_W'(cand_c)]) begin
                found_c   = 1'b1;
                gnt_idx_c = IDX_W'(cand_c);
            end
        end
        gnt_c = found_c ? (NUM_REQ'(1) << gnt_idx_c) : '0;
    end

    // Pointer moves only when a grant is actually taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (advance && found_c) begin
            ptr_q <= IDX_W'((32'(gnt_idx_c) + 32'd1) % NUM_REQ);
        end
    end

endmodule

// File: rtl/xilinx_sp_bram_arbiter.sv
// Shares one single-port BRAM between NUM_REQ requesters.
// One access is issued per cycle; reads are tagged and their data is steered
// back to the issuing requester after the BRAM latency (1 + DO_REG).
//   clk, rst_n            : clock, async active-low reset
//   req_valid/req_ready   : per-requester handshake (ready is the one-hot grant)
//   req_wr/be/addr/wdata  : packed per-requester request payload
//   rsp_valid/rsp_data    : one-hot read response strobe, shared data bus
//   bram_en/we/addr/di    : registered BRAM port drive
//   bram_regce            : output-register enable (only used when DO_REG=1)
//   bram_do               : BRAM read data
module xilinx_sp_bram_arbiter
    import xilinx_primitive_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 36,
    parameter int unsigned WE_WIDTH   = 4,
    parameter int unsigned DO_REG     = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             req_wr,
    input  logic [NUM_REQ*WE_WIDTH-1:0]    req_be,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_WIDTH-1:0]          rsp_data,
    output logic                           bram_en,
    output logic [BRAM_WE_W-1:0]           bram_we,
    output logic [BRAM_ADDR_W-1:0]         bram_addr,
    output logic [DATA_WIDTH-1:0]          bram_di,
    output logic                           bram_regce,
    input  logic [DATA_WIDTH-1:0]          bram_do
);

    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned RD_LAT = rd_latency(DO_REG);
    localparam int unsigned TAG_W  = $bits(rd_tag_t);

    logic [NUM_REQ-1:0]    gnt_c;
    logic [IDX_W-1:0]      gnt_idx_c;
    logic                  accept_c;
    logic                  sel_wr_c;
    logic [WE_WIDTH-1:0]   sel_be_c;
    logic [ADDR_WIDTH-1:0] sel_addr_c;
    logic [DATA_WIDTH-1:0] sel_wdata_c;
    rd_tag_t               tag_in_c;
    rd_tag_t [RD_LAT-1:0]  tag_q;

    xilinx_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_valid),
        .advance   (accept_c),
        .gnt_c     (gnt_c),
        .gnt_idx_c (gnt_idx_c)
    );

    // No grants while reset is asserted, even if requesters hold valid.
    assign req_ready = gnt_c & {NUM_REQ{rst_n}};
    assign accept_c  = |req_ready;

    // Read data is a straight passthrough; rsp_valid qualifies it.
    assign rsp_data  = bram_do;

    // Payload of the granted requester.
    always_comb begin
        sel_wr_c    = req_wr[gnt_idx_c];
        sel_be_c    = req_be[32'(gnt_idx_c)*WE_WIDTH +: WE_WIDTH];
        sel_addr_c  = req_addr[32'(gnt_idx_c)*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata_c = req_wdata[32'(gnt_idx_c)*DATA_WIDTH +: DATA_WIDTH];
        tag_in_c.vld = accept_c && !sel_wr_c;
        tag_in_c.id  = TAG_ID_W'(gnt_idx_c);
    end

    // Issue register: the accepted request drives the BRAM port next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bram_en   <= 1'b0;
            bram_we   <= '0;
            bram_addr <= '0;
            bram_di   <= '0;
        end else begin
            bram_en <= accept_c;
            bram_we <= (accept_c && sel_wr_c) ? BRAM_WE_W'(sel_be_c) : '0;
            if (accept_c) begin
                bram_addr <= BRAM_ADDR_W'(sel_addr_c);
                bram_di   <= sel_wdata_c;
            end
        end
    end

    // Read tag shift register; index 0 is aligned with the issue cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q <= '0;
        end else begin
            tag_q <= (RD_LAT*TAG_W)'({tag_q, tag_in_c});
        end
    end

    // Response strobe lines up with the cycle bram_do carries the read data;
    // regce fires the cycle the read sits in the second stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= '0;
            bram_regce <= 1'b0;
        end else begin
            rsp_valid  <= tag_q[RD_LAT-1].vld ? (NUM_REQ'(1) << tag_q[RD_LAT-1].id) : '0;
            bram_regce <= (DO_REG != 0) && tag_q[0].vld;
        end
    end

endmodule
